// File: rtl/axis_velocity_ctrl.sv
// Per-axis velocity integrator: thrust commands in, signed velocity out once per tick.
// Optional clamping on overflow is enabled by defining AXIS_VEL_SATURATE_EN.
module axis_velocity_ctrl #(
    parameter int unsigned W        = 16,
    parameter int unsigned ACC_W    = 4,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [ACC_W-1:0]    cmd_accel,
    input  logic [7:0]          cmd_burn,
    output logic signed [W-1:0] vel_out,
    output logic                vel_valid,
    output logic                busy,
    output logic                sat
);

    localparam int unsigned CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {StIdle, StBurn, StBrake} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [W-1:0]     vel_q;
    logic             valid_q;
    logic             sat_q;
    logic             neg_q;
    logic [ACC_W-1:0] accel_q;
    logic [7:0]       rem_q;

    logic             upd;
    logic             tick;
    logic [W:0]       vel_ext;
    logic [W:0]       acc_ext;
    logic [W:0]       brk_a;
    logic [W:0]       abs_v;
    logic [W:0]       burn_sum;
    logic [W:0]       brake_sum;
    logic [W-1:0]     burn_next;
    logic [W-1:0]     brake_next;
    logic             burn_ovf;

    // The update edge precedes the tick cycle so vel_out and vel_valid appear together.
    assign upd  = (cnt_q == CW'(TICK_DIV - 2));
    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        vel_ext   = {vel_q[W-1], vel_q};
        acc_ext   = {{(W + 1 - ACC_W){1'b0}}, accel_q};
        brk_a     = (accel_q == '0) ? (W + 1)'(1) : acc_ext;
        abs_v     = vel_ext[W] ? (~vel_ext + (W + 1)'(1)) : vel_ext;
        burn_sum  = neg_q ? (vel_ext - acc_ext) : (vel_ext + acc_ext);
        brake_sum = vel_ext[W] ? (vel_ext + brk_a) : (vel_ext - brk_a);
        brake_next = (abs_v <= brk_a) ? '0 : brake_sum[W-1:0];
`ifdef AXIS_VEL_SATURATE_EN
        burn_ovf = (burn_sum[W] != burn_sum[W-1]);
        if (burn_ovf) begin
            burn_next = burn_sum[W] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
        end else begin
            burn_next = burn_sum[W-1:0];
        end
`else
        burn_ovf  = 1'b0;
        burn_next = burn_sum[W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vel_q   <= '0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
            neg_q   <= 1'b0;
            accel_q <= '0;
            rem_q   <= '0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + CW'(1);
            valid_q <= upd;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        sat_q   <= 1'b0;
                        neg_q   <= (cmd_mode == 2'b10);
                        accel_q <= cmd_accel;
                        rem_q   <= cmd_burn;
                        if ((cmd_mode == 2'b01 || cmd_mode == 2'b10) && cmd_burn != 8'd0) begin
                            state_q <= StBurn;
                        end else if (cmd_mode == 2'b11 && vel_q != '0) begin
                            state_q <= StBrake;
                        end
                    end
                end
                StBurn: begin
                    if (upd) begin
                        vel_q <= burn_next;
                        rem_q <= rem_q - 8'd1;
                        if (burn_ovf) begin
                            sat_q <= 1'b1;
                        end
                    end
                    // Leave at the end of the strobe cycle so ready rises the cycle after.
                    if (tick && rem_q == 8'd0) begin
                        state_q <= StIdle;
                    end
                end
                StBrake: begin
                    if (upd) begin
                        vel_q <= brake_next;
                    end
                    if (tick && vel_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vel_out   = vel_q;
    assign vel_valid = valid_q;
    assign busy      = (state_q != StIdle);
    assign sat       = sat_q;
    assign cmd_ready = (state_q == StIdle) & ~rst;

endmodule

// File: doc/axis_velocity_ctrl.md
# axis_velocity_ctrl

Per-axis velocity integrator for the spaceship command module. Accepts thrust commands (accelerate, decelerate, brake) through a valid/ready handshake and integrates signed acceleration into a signed velocity once per update tick. Sits directly upstream of the axis position stage, which consumes `vel_out` on every `vel_valid` strobe. One instance per axis (x, y, z).

## Interface

Parameters:
- `W`, 16: velocity width, signed two's complement.
- `ACC_W`, 4: acceleration magnitude width, unsigned.
- `TICK_DIV`, 4: clock cycles per integration tick, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: block can accept a command.
- `cmd_mode` input 2: 00 coast/no-op, 01 accelerate (+), 10 decelerate (−), 11 brake toward zero.
- `cmd_accel` input ACC_W: acceleration magnitude per tick.
- `cmd_burn` input 8: burn length in ticks (modes 01/10 only).
- `vel_out` output W: current signed velocity, registered.
- `vel_valid` output 1: one-cycle strobe on every tick; `vel_out` is valid for that tick.
- `busy` output 1: high in BURN or BRAKE.
- `sat` output 1: velocity clamped since the last accepted command.

## Operation

- Tick counter: free-running, 0..TICK_DIV−1. Tick occurs when counter = TICK_DIV−1.
- States:
  - IDLE: `cmd_ready`=1.
  - BURN: on each tick, v ← v ± accel; remaining count decrements. Transition to IDLE on the tick that consumes the last count.
  - BRAKE: on each tick, if |v| ≤ a then v ← 0 and transition to IDLE; otherwise v moves toward zero by a.
- Accept: `cmd_valid & cmd_ready` latches mode, accel and burn, and clears `sat`.
  - Mode 00 stays in IDLE.
  - Modes 01/10 enter BURN; with burn=0 they stay in IDLE with no change.
  - Mode 11 enters BRAKE; if v=0 it stays in IDLE.
- Brake with accel=0 uses a=1. Burn with accel=0 holds v for the burn duration.
- Arithmetic: accel is zero-extended to W+1 bits and the sum is computed in W+1 bits; overflow is handled per Configuration.
- `busy` = (state ≠ IDLE). `cmd_ready` = (state = IDLE) & ~`rst`.

## Timing

- Reset values: `vel_out`=0, `vel_valid`=0, `busy`=0, `sat`=0, tick counter=0, state IDLE. `cmd_ready`=0 while `rst` is high and 1 on the first cycle after.
- First `vel_valid` occurs on cycle TICK_DIV−1 after reset release. After that, strobes repeat every TICK_DIV cycles in every state.
- Update latency: on a tick in BURN/BRAKE, the new `vel_out` is visible in the same cycle `vel_valid` is high, because both are registered together.
- Command accepted in the same cycle as a tick: that tick is processed as IDLE (no change). The first update happens on the next tick.
- Burn of N ticks produces exactly N updates. `cmd_ready` rises the cycle after the Nth update strobe.
- Commands are never accepted while busy; `cmd_valid` may stay high and is held off by `cmd_ready`.
- Reset mid-BURN/BRAKE: abandons the command and forces all reset values on the next edge.

## Configuration

- `AXIS_VEL_SATURATE_EN` defined:
  - Overflow clamps to +2^(W−1)−1 or −2^(W−1).
  - `sat` sets and stays set until the next accepted command.
  - BURN continues counting while clamped.
- Undefined:
  - Velocity wraps modulo 2^W.
  - `sat` is tied to 0.

## Test plan

- Reset, then no commands (TICK_DIV=4) -> `vel_out`=0; `vel_valid` pulses at cycles 3, 7, 11; `cmd_ready`=1; `busy`=0.
- Mode 01, accel=3, burn=5 from v=0 -> successive strobes show 3, 6, 9, 12, 15; `busy` falls and `cmd_ready` rises the cycle after the strobe showing 15.
- Mode 10, accel=4, burn=5 from v=15 -> 11, 7, 3, −1, −5. Then mode 11, accel=2 -> −3, −1, 0, then IDLE.
- W=8, mode 01, accel=15, burn=9 from v=0:
  - With `AXIS_VEL_SATURATE_EN`: 15 … 120, then 127 with `sat`=1.
  - Without it: 9th strobe shows −121 and `sat`=0.
- Command asserted on a tick cycle (mode 01, accel=1, burn=1) -> no change at that tick; v+1 on the following tick.
- `rst` asserted mid-BURN at v=6 -> next cycle `vel_out`=0, `busy`=0, `sat`=0; the next strobe is TICK_DIV−1 cycles after `rst` deasserts.
